// File: rtl/pipe3_pkg.sv
// Shared definitions for the pipe3_fwd pipeline: ALU opcodes, instruction field
// positions and the decoded S1 payload.
package pipe3_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRL = 3'd6;
   localparam logic [2:0] OP_SLT = 3'd7;

   localparam int unsigned OP_MSB    = 31;
   localparam int unsigned OP_LSB    = 29;
   localparam int unsigned SRC_BIT   = 28;
   localparam int unsigned WE_BIT    = 27;
   localparam int unsigned WSEL_MSB  = 26;
   localparam int unsigned WSEL_LSB  = 22;
   localparam int unsigned RSEL1_MSB = 21;
   localparam int unsigned RSEL1_LSB = 17;
   localparam int unsigned RSV_BIT   = 16;
   localparam int unsigned RSEL2_MSB = 15;
   localparam int unsigned RSEL2_LSB = 11;
   localparam int unsigned IMM_MSB   = 15;
   localparam int unsigned IMM_LSB   = 0;

   typedef struct packed {
      logic        valid;
      logic [2:0]  op;
      logic        src;
      logic        we;
      logic [4:0]  wsel;
      logic [4:0]  rsel1;
      logic [4:0]  rsel2;
      logic [15:0] imm;
   } s1_t;

   // Split an accepted instruction word into its S1 fields.
   function automatic s1_t decode(input logic [31:0] ins);
      s1_t d;
      d.valid = 1'b1;
      d.op    = ins[OP_MSB:OP_LSB];
      d.src   = ins[SRC_BIT];
      d.we    = ins[WE_BIT];
      d.wsel  = ins[WSEL_MSB:WSEL_LSB];
      d.rsel1 = ins[RSEL1_MSB:RSEL1_LSB];
      d.rsel2 = ins[RSEL2_MSB:RSEL2_LSB];
      d.imm   = ins[IMM_MSB:IMM_LSB];
      return d;
   endfunction

endpackage

// File: rtl/pipe3_alu.sv
// Combinational ALU for pipe3_fwd; results wrap modulo 2^DATA_W.
module pipe3_alu
   import pipe3_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_y_c
);

   localparam int unsigned SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] w_shamt;

   assign w_shamt = i_b[SH_W-1:0];

   always_comb begin
      o_y_c = '0;
      case (i_op)
         OP_ADD: o_y_c = i_a + i_b;
         OP_SUB: o_y_c = i_a - i_b;
         OP_AND: o_y_c = i_a & i_b;
         OP_OR:  o_y_c = i_a | i_b;
         OP_XOR: o_y_c = i_a ^ i_b;
         OP_SLL: o_y_c = i_a << w_shamt;
         OP_SRL: o_y_c = i_a >> w_shamt;
         OP_SLT: o_y_c = DATA_W'($signed(i_a) < $signed(i_b));
      endcase
   end

endmodule

// File: rtl/pipe3_fwd.sv
// Three-stage decode/execute/writeback pipeline with register file and RAW handling.
// Define PIPE3_FWD_FORWARD_EN for operand forwarding; otherwise hazards interlock.
module pipe3_fwd
   import pipe3_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned IMM_SIGNED = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [4:0]        out_wsel,
   output logic              out_we
);

   s1_t               r_s1;
   logic              r_s2_valid;
   logic              r_s2_we;
   logic [2:0]        r_s2_op;
   logic [4:0]        r_s2_wsel;
   logic [DATA_W-1:0] r_s2_a;
   logic [DATA_W-1:0] r_s2_b;
   logic [DATA_W-1:0] r_regs [32];

   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_alu_y;
   logic              w_s2_wr;
   logic              w_s3_wr;
   logic              w_h1_s2;
   logic              w_h1_s3;
   logic              w_h2_s2;
   logic              w_h2_s3;
   logic              w_stall;
   logic              w_xfer;
   logic              w_unused;

   // Selects that name a real, writable register (r0 and out-of-range excluded).
   function automatic logic sel_live(input logic [4:0] sel);
      return (sel != 5'd0) && (32'(sel) < NUM_REGS);
   endfunction

   assign w_unused = instr[RSV_BIT];

   assign w_rd1 = sel_live(r_s1.rsel1) ? r_regs[r_s1.rsel1] : '0;
   assign w_rd2 = sel_live(r_s1.rsel2) ? r_regs[r_s1.rsel2] : '0;

   always_comb begin
      w_imm_ext = DATA_W'(r_s1.imm);
      if (IMM_SIGNED != 0) w_imm_ext = DATA_W'($signed(r_s1.imm));
   end

   assign w_s2_wr = r_s2_valid & r_s2_we;
   assign w_s3_wr = out_valid & out_we;
   assign w_h1_s2 = r_s1.valid & sel_live(r_s1.rsel1) & w_s2_wr & (r_s2_wsel == r_s1.rsel1);
   assign w_h1_s3 = r_s1.valid & sel_live(r_s1.rsel1) & w_s3_wr & (out_wsel == r_s1.rsel1);
   assign w_h2_s2 = r_s1.valid & ~r_s1.src & sel_live(r_s1.rsel2) & w_s2_wr
                  & (r_s2_wsel == r_s1.rsel2);
   assign w_h2_s3 = r_s1.valid & ~r_s1.src & sel_live(r_s1.rsel2) & w_s3_wr
                  & (out_wsel == r_s1.rsel2);

`ifdef PIPE3_FWD_FORWARD_EN
   // Younger S2 result takes priority over the S3 result.
   assign w_stall  = 1'b0;
   assign in_ready = rst;

   always_comb begin
      w_op_a = w_rd1;
      if (w_h1_s2)      w_op_a = w_alu_y;
      else if (w_h1_s3) w_op_a = out_data;
      w_op_b = w_rd2;
      if (r_s1.src)     w_op_b = w_imm_ext;
      else if (w_h2_s2) w_op_b = w_alu_y;
      else if (w_h2_s3) w_op_b = out_data;
   end
`else
   // Hold S1 until the producer has been written into the register file.
   assign w_stall  = w_h1_s2 | w_h1_s3 | w_h2_s2 | w_h2_s3;
   assign in_ready = rst & ~w_stall;
   assign w_op_a   = w_rd1;
   assign w_op_b   = r_s1.src ? w_imm_ext : w_rd2;
`endif

   assign w_xfer = in_valid & in_ready;

   pipe3_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_op  (r_s2_op),
      .i_a   (r_s2_a),
      .i_b   (r_s2_b),
      .o_y_c (w_alu_y)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1       <= '0;
         r_s2_valid <= 1'b0;
         r_s2_we    <= 1'b0;
         r_s2_op    <= '0;
         r_s2_wsel  <= '0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
         out_valid  <= 1'b0;
         out_we     <= 1'b0;
         out_wsel   <= '0;
         out_data   <= '0;
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else begin
         if (w_s3_wr && sel_live(out_wsel)) r_regs[out_wsel] <= out_data;

         if (!w_stall) r_s1 <= w_xfer ? decode(instr) : '0;

         // A stalled S1 sends a bubble (valid and we cleared) into S2.
         r_s2_valid <= r_s1.valid & ~w_stall;
         r_s2_we    <= r_s1.valid & r_s1.we & ~w_stall;
         r_s2_op    <= r_s1.op;
         r_s2_wsel  <= r_s1.wsel;
         r_s2_a     <= w_op_a;
         r_s2_b     <= w_op_b;

         out_valid  <= r_s2_valid;
         out_we     <= r_s2_valid & r_s2_we;
         out_wsel   <= r_s2_wsel;
         out_data   <= w_alu_y;
      end
   end

endmodule
